// File: rtl/pdh_axi_pkg.sv
// pdh_axi_pkg: AXI encodings and write-FSM state shared by
// axi_wr_responder and dma_controller.
package pdh_axi_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } wr_state_e;

endpackage

// File: rtl/axi_wr_responder.sv
// axi_wr_responder: single-outstanding AXI write slave that
// turns INCR bursts into registered 64-bit memory writes.
module axi_wr_responder
   import pdh_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          DEPTH_WORDS = 2048
) (
   input  logic                           aclk,
   input  logic                           rst_i,
   input  logic [31:0]                    s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [3:0]                     s_axi_awlen,
   input  logic [2:0]                     s_axi_awsize,
   input  logic [1:0]                     s_axi_awburst,
   input  logic [63:0]                    s_axi_wdata,
   input  logic [7:0]                     s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   input  logic                           s_axi_wlast,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   output logic [1:0]                     s_axi_bresp,
   output logic                           mem_we_o,
   output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
   output logic [63:0]                    mem_wdata_o,
   output logic [7:0]                     mem_wstrb_o,
   output logic [15:0]                    err_cnt_o
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

   wr_state_e     state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [3:0]    len_q, len_d;
   logic [3:0]    beat_q, beat_d;
   logic          bad_q, bad_d;
   logic          err_q, err_d;
   logic          ovr_q, ovr_d;
   logic          bvalid_q, bvalid_d;
   logic [1:0]    bresp_q, bresp_d;
   logic          we_q, we_d;
   logic [AW-1:0] maddr_q, maddr_d;
   logic [63:0]   wdata_q, wdata_d;
   logic [7:0]    wstrb_q, wstrb_d;
   logic [15:0]   ecnt_q, ecnt_d;

   logic [31:0]   off;
   logic [31:0]   widx;
   logic [31:0]   last_idx;
   logic          aw_bad;
   logic          aw_hs;
   logic          w_hs;
   logic          b_hs;
   logic          early;
   logic          missing;

   // Legality of the incoming AW, evaluated on the live channel
   always_comb begin
      off      = s_axi_awaddr - BASE_ADDR;
      widx     = off >> 3;
      last_idx = widx + 32'(s_axi_awlen);
      aw_bad   = (s_axi_awsize != AXI_SIZE_8B)
              || (s_axi_awburst != AXI_BURST_INCR)
              || (s_axi_awaddr[2:0] != 3'b000)
              || (s_axi_awaddr < BASE_ADDR)
              || (last_idx >= DEPTH_L);
   end

   assign s_axi_awready = (state_q == WR_IDLE) && !rst_i;
   assign s_axi_wready  = (state_q == WR_DATA) && !rst_i;
   assign s_axi_bvalid  = bvalid_q && !rst_i;
   assign s_axi_bresp   = rst_i ? 2'b00 : bresp_q;

   assign aw_hs = s_axi_awready && s_axi_awvalid;
   assign w_hs  = s_axi_wready && s_axi_wvalid;
   assign b_hs  = s_axi_bvalid && s_axi_bready;

   // ovr_q marks beats past awlen: accepted, never written
   assign early   = s_axi_wlast && (beat_q < len_q) && !ovr_q;
   assign missing = !s_axi_wlast && (beat_q == len_q) && !ovr_q;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      beat_d   = beat_q;
      bad_d    = bad_q;
      err_d    = err_q;
      ovr_d    = ovr_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      we_d     = 1'b0;
      maddr_d  = maddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      ecnt_d   = ecnt_q;
      unique case (state_q)
         WR_IDLE: begin
            if (aw_hs) begin
               base_d  = widx[AW-1:0];
               len_d   = s_axi_awlen;
               beat_d  = 4'd0;
               bad_d   = aw_bad;
               err_d   = aw_bad;
               ovr_d   = 1'b0;
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            if (w_hs) begin
               beat_d  = beat_q + 4'd1;
               we_d    = !bad_q && !ovr_q;
               maddr_d = base_q + AW'(beat_q);
               wdata_d = s_axi_wdata;
               wstrb_d = s_axi_wstrb;
               if (early || missing) begin
                  err_d = 1'b1;
               end
               if (missing) begin
                  ovr_d = 1'b1;
               end
               if (s_axi_wlast) begin
                  state_d = WR_RESP;
               end
            end
         end
         WR_RESP: begin
            // bvalid rises one cycle into RESP so bresp is a clean register
            if (!bvalid_q) begin
               bvalid_d = 1'b1;
               bresp_d  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (b_hs) begin
               bvalid_d = 1'b0;
               bresp_d  = AXI_RESP_OKAY;
               state_d  = WR_IDLE;
               if (err_q && (ecnt_q != 16'hFFFF)) begin
                  ecnt_d = ecnt_q + 16'd1;
               end
            end
         end
         default: begin
            state_d = WR_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst_i) begin
         state_q  <= WR_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         bad_q    <= 1'b0;
         err_q    <= 1'b0;
         ovr_q    <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= '0;
         we_q     <= 1'b0;
         maddr_q  <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         bad_q    <= bad_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         we_q     <= we_d;
         maddr_q  <= maddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign mem_we_o    = we_q && !rst_i;
   assign mem_addr_o  = rst_i ? '0 : maddr_q;
   assign mem_wdata_o = rst_i ? '0 : wdata_q;
   assign mem_wstrb_o = rst_i ? '0 : wstrb_q;
   assign err_cnt_o   = rst_i ? '0 : ecnt_q;

endmodule

// File: tb/tb_axi_wr_responder.sv
// tb_axi_wr_responder: directed bursts with a write/response
// scoreboard filled from a bench-side legality model.
module tb_axi_wr_responder;
   import pdh_axi_pkg::*;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 2048;
   localparam int          AW    = 11;

   logic          aclk = 1'b0;
   logic          rst_i;
   logic [31:0]   s_axi_awaddr;
   logic          s_axi_awvalid;
   logic          s_axi_awready;
   logic [3:0]    s_axi_awlen;
   logic [2:0]    s_axi_awsize;
   logic [1:0]    s_axi_awburst;
   logic [63:0]   s_axi_wdata;
   logic [7:0]    s_axi_wstrb;
   logic          s_axi_wvalid;
   logic          s_axi_wready;
   logic          s_axi_wlast;
   logic          s_axi_bvalid;
   logic          s_axi_bready;
   logic [1:0]    s_axi_bresp;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [63:0]   mem_wdata_o;
   logic [7:0]    mem_wstrb_o;
   logic [15:0]   err_cnt_o;

   axi_wr_responder dut (
      .aclk          (aclk),
      .rst_i         (rst_i),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_awsize  (s_axi_awsize),
      .s_axi_awburst (s_axi_awburst),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_bresp   (s_axi_bresp),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_wstrb_o   (mem_wstrb_o),
      .err_cnt_o     (err_cnt_o)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [63:0]   data;
      logic [7:0]    strb;
   } wr_t;

   wr_t        wq[$];
   logic [1:0] bq[$];
   int         n_chk    = 0;
   int         n_fail   = 0;
   int         exp_errs = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Memory port monitor: each write must match the queue head
   always @(negedge aclk) begin : mon
      wr_t e;
      if (mem_we_o === 1'b1) begin
         n_chk++;
         assert (wq.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_write observed addr=%0d expected none",
                   mem_addr_o);
         end
         if (wq.size() != 0) begin
            e = wq.pop_front();
            n_chk++;
            assert (mem_addr_o === e.addr && mem_wdata_o === e.data
                    && mem_wstrb_o === e.strb) else begin
               n_fail++;
               $error("FAIL write observed=%0d/%0h/%0h expected=%0d/%0h/%0h",
                      mem_addr_o, mem_wdata_o, mem_wstrb_o,
                      e.addr, e.data, e.strb);
            end
         end
      end
   end

   task automatic wait_hi(input int which, input string tag);
      int   n;
      logic s;
      n = 0;
      forever begin
         @(negedge aclk);
         s = (which == 0) ? s_axi_awready :
             (which == 1) ? s_axi_wready  : s_axi_bvalid;
         if (s === 1'b1 || n >= 100) break;
         n++;
      end
      n_chk++;
      assert (n < 100) else begin
         n_fail++;
         $error("FAIL %s wait observed=%0d cycles expected <100", tag, n);
      end
   endtask

   task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int last_at, input int gap,
                            input int bdelay, input logic [63:0] dbase,
                            input string tag);
      longint     idx;
      bit         legal;
      logic [1:0] eresp;
      logic [1:0] e;
      logic [7:0] st;
      idx   = (longint'(addr) - longint'(BASE)) / 8;
      legal = (size == 3'd3) && (burst == 2'd1) && (addr % 8 == 0)
           && (addr >= BASE) && (idx + longint'(len) < longint'(DEPTH));
      eresp = (legal && last_at == int'(len)) ? 2'b00 : 2'b10;
      bq.push_back(eresp);
      @(posedge aclk); #1;
      s_axi_awaddr  = addr;
      s_axi_awlen   = len;
      s_axi_awsize  = size;
      s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      wait_hi(0, {tag, "_aw"});
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= last_at; i++) begin
         if (gap > 0 && i % gap == gap - 1) begin
            s_axi_wvalid = 1'b0;
            @(posedge aclk); #1;
         end
         st = ~8'(i);
         s_axi_wdata  = dbase + 64'(i);
         s_axi_wstrb  = st;
         s_axi_wlast  = (i == last_at);
         s_axi_wvalid = 1'b1;
         wait_hi(1, {tag, "_w"});
         if (legal && i <= int'(len))
            wq.push_back('{addr: AW'(idx + longint'(i)),
                           data: dbase + 64'(i), strb: st});
         @(posedge aclk); #1;
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      wait_hi(2, {tag, "_b"});
      for (int k = 0; k < bdelay; k++) begin
         chk({tag, "_bhold_valid"}, 64'(s_axi_bvalid), 64'd1);
         chk({tag, "_bhold_resp"}, 64'(s_axi_bresp), 64'(eresp));
         @(negedge aclk);
      end
      s_axi_bready = 1'b1;
      e = bq.pop_front();
      chk({tag, "_bresp"}, 64'(s_axi_bresp), 64'(e));
      @(posedge aclk); #1;
      s_axi_bready = 1'b0;
      if (e != 2'b00) exp_errs++;
      @(negedge aclk);
      chk({tag, "_bvalid_low"}, 64'(s_axi_bvalid), 64'd0);
      chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(exp_errs));
      chk({tag, "_idle"}, 64'(s_axi_awready), 64'd1);
      chk({tag, "_drained"}, 64'(wq.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, 64'(s_axi_awready), 64'd0);
      chk({tag, "_wready"},  64'(s_axi_wready),  64'd0);
      chk({tag, "_bvalid"},  64'(s_axi_bvalid),  64'd0);
      chk({tag, "_bresp"},   64'(s_axi_bresp),   64'd0);
      chk({tag, "_we"},      64'(mem_we_o),      64'd0);
      chk({tag, "_addr"},    64'(mem_addr_o),    64'd0);
      chk({tag, "_wdata"},   mem_wdata_o,        64'd0);
      chk({tag, "_wstrb"},   64'(mem_wstrb_o),   64'd0);
      chk({tag, "_errcnt"},  64'(err_cnt_o),     64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i         = 1'b1;
      s_axi_awaddr  = '0;
      s_axi_awvalid = 1'b0;
      s_axi_awlen   = '0;
      s_axi_awsize  = '0;
      s_axi_awburst = '0;
      s_axi_wdata   = '0;
      s_axi_wstrb   = '0;
      s_axi_wvalid  = 1'b0;
      s_axi_wlast   = 1'b0;
      s_axi_bready  = 1'b0;

      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk_reset_outputs("rst0");
      @(posedge aclk); #1;
      rst_i = 1'b0;
      @(negedge aclk);
      chk("rst0_release_awready", 64'(s_axi_awready), 64'd1);

      // 16-beat burst, no stalls
      run_burst(BASE, 4'd15, 3'd3, 2'd1, 15, 0, 0, 64'd0, "basic");

      // two bursts with wvalid gaps and delayed bready
      run_burst(BASE, 4'd15, 3'd3, 2'd1, 15, 4, 3, 64'd0, "b2b_a");
      run_burst(BASE + 32'h80, 4'd15, 3'd3, 2'd1, 15, 4, 3, 64'd16,
                "b2b_b");

      // FIXED burst: accepted, never written
      run_burst(BASE, 4'd3, 3'd3, 2'd0, 3, 0, 0, 64'h100, "fixed");

      // early wlast on beat 7, then a legal burst
      run_burst(BASE + 32'h200, 4'd15, 3'd3, 2'd1, 7, 0, 1, 64'h200,
                "early");
      run_burst(BASE + 32'h400, 4'd3, 3'd3, 2'd1, 3, 0, 0, 64'h300,
                "after_early");

      // last word beyond the memory
      run_burst(BASE + 32'((DEPTH - 8) * 8), 4'd15, 3'd3, 2'd1, 15, 0, 0,
                64'h400, "range");

      // missing wlast: two extra beats accepted but not written
      run_burst(BASE + 32'h600, 4'd3, 3'd3, 2'd1, 5, 0, 0, 64'h500,
                "nolast");

      // misaligned, below base, wrong size
      run_burst(BASE + 32'h4, 4'd1, 3'd3, 2'd1, 1, 0, 0, 64'h600, "unalign");
      run_burst(BASE - 32'h100, 4'd1, 3'd3, 2'd1, 1, 0, 0, 64'h700, "below");
      run_burst(BASE, 4'd1, 3'd2, 2'd1, 1, 0, 0, 64'h800, "size4");

      // reset asserted while beat 5 is on the bus
      @(posedge aclk); #1;
      s_axi_awaddr  = BASE + 32'h800;
      s_axi_awlen   = 4'd15;
      s_axi_awsize  = 3'd3;
      s_axi_awburst = 2'd1;
      s_axi_awvalid = 1'b1;
      wait_hi(0, "mrst_aw");
      @(posedge aclk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_axi_wdata  = 64'hA000 + 64'(i);
         s_axi_wstrb  = 8'hFF;
         s_axi_wlast  = 1'b0;
         s_axi_wvalid = 1'b1;
         wait_hi(1, "mrst_w");
         wq.push_back('{addr: AW'(256 + i), data: 64'hA000 + 64'(i),
                        strb: 8'hFF});
         @(posedge aclk); #1;
      end
      s_axi_wdata = 64'hA005;
      rst_i       = 1'b1;
      // beat 4 write is still pending in the output register
      void'(wq.pop_back());
      @(negedge aclk);
      chk_reset_outputs("mrst");
      @(posedge aclk); #1;
      s_axi_wvalid = 1'b0;
      @(negedge aclk);
      chk_reset_outputs("mrst2");
      @(posedge aclk); #1;
      rst_i    = 1'b0;
      exp_errs = 0;
      @(negedge aclk);
      chk("mrst_release_awready", 64'(s_axi_awready), 64'd1);
      chk("mrst_release_bvalid", 64'(s_axi_bvalid), 64'd0);
      repeat (3) begin
         @(negedge aclk);
         chk("mrst_no_b", 64'(s_axi_bvalid), 64'd0);
      end
      chk("mrst_drained", 64'(wq.size()), 64'd0);

      run_burst(BASE + 32'h40, 4'd1, 3'd3, 2'd1, 1, 0, 0, 64'h900, "recover");

      repeat (4) @(posedge aclk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_wr_responder.md
AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of word 0 of the target memory.
REQ-002 SHALL have parameter DEPTH_WORDS, default 2048, number of 64-bit words in the target memory (power of two).
REQ-003 SHALL use a single clock and a synchronous, active-high reset, with ports named as listed below.
REQ-004 SHALL have port aclk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_axi_awaddr  in  32  burst start byte address.
REQ-007 SHALL have port s_axi_awvalid  in  1  AW valid.
REQ-008 SHALL have port s_axi_awready  out  1  AW ready.
REQ-009 SHALL have port s_axi_awlen  in  4  beats minus 1.
REQ-010 SHALL have port s_axi_awsize  in  3  bytes per beat, log2.
REQ-011 SHALL have port s_axi_awburst  in  2  burst type.
REQ-012 SHALL have port s_axi_wdata  in  64  write data.
REQ-013 SHALL have port s_axi_wstrb  in  8  byte enables.
REQ-014 SHALL have port s_axi_wvalid  in  1  W valid.
REQ-015 SHALL have port s_axi_wready  out  1  W ready.
REQ-016 SHALL have port s_axi_wlast  in  1  final beat marker.
REQ-017 SHALL have ports s_axi_bvalid  out  1 and s_axi_bready  in  1, the B handshake.
REQ-018 SHALL have port s_axi_bresp  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-019 SHALL have ports mem_we_o  out  1, mem_addr_o  out  log2(DEPTH_WORDS), mem_wdata_o  out  64, mem_wstrb_o  out  8, forming the memory write port.
REQ-020 SHALL have port err_cnt_o  out  16  count of SLVERR responses, saturating.

Function
REQ-021 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, with one outstanding burst only.
REQ-022 SHALL, in IDLE, drive awready=1 and wready=0; the AW handshake latches addr/len/size/burst and moves the FSM to DATA on the next cycle.
REQ-023 SHALL, in DATA, drive awready=0 and wready=1; each W handshake increments a 4-bit beat counter that starts at 0.
REQ-024 SHALL register each accepted beat: mem_we_o pulses 1 cycle after the handshake, with mem_addr_o = ((awaddr-BASE_ADDR)>>3)+beat.
REQ-025 SHALL raise SLVERR and suppress all mem_we_o for the whole burst if awsize!=3'b011, awburst!=2'b01 (INCR), awaddr[2:0]!=0, awaddr<BASE_ADDR, or the last word index >= DEPTH_WORDS.
REQ-026 SHALL respond to early wlast (beat<awlen) with SLVERR: the beat is written if the burst is otherwise legal, and the FSM goes to RESP.
REQ-027 SHALL respond to a missing wlast on beat==awlen with SLVERR: the beat is written, later beats are accepted with writes suppressed until wlast, then the FSM goes to RESP.
REQ-028 SHALL, in RESP, hold bvalid=1 with a stable bresp until bready; the FSM returns to IDLE the cycle after the handshake.
REQ-029 SHALL produce a minimum back-to-back burst period of awlen+4 cycles; wvalid gaps stretch DATA without data loss.
REQ-030 SHALL increment err_cnt_o on each SLVERR B handshake and hold it at 16'hFFFF once saturated.

Reset
REQ-031 SHALL, while rst_i=1, force: awready=0, wready=0, bvalid=0, bresp=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, err_cnt_o=0, FSM=IDLE; awready rises on the first cycle after reset release.
REQ-032 SHALL let reset asserted mid-burst abandon the burst with no B response; any pending mem_we_o is dropped.

Structure
REQ-033 SHALL place AXI burst/resp/size constants and the FSM state typedef in package pdh_axi_pkg, shared with dma_controller.
REQ-034 SHALL be a single flat module with no sub-modules; the memory is external.

Verification
REQ-035 SHALL verify: AW 0x1000_0000, len 15, size 3, INCR, 16 beats of data 0..15 with no stalls -> mem addrs 0..15 with data 0..15, bresp OKAY, err_cnt 0.
REQ-036 SHALL verify: two back-to-back bursts at 0x1000_0000 and 0x1000_0080 with wvalid low every 4th cycle and bready delayed 3 cycles -> words 0..31 written in order, two OKAY responses, no lost beats.
REQ-037 SHALL verify: awburst=2'b00 (FIXED), len 3 -> 4 beats accepted, mem_we_o never asserted, bresp SLVERR, err_cnt 1.
REQ-038 SHALL verify: len 15 with wlast on beat 7 -> 8 writes, SLVERR, FSM back in IDLE; the next legal burst returns OKAY.
REQ-039 SHALL verify: awaddr BASE+(DEPTH_WORDS-8)*8 with len 15 -> no writes, SLVERR.
REQ-040 SHALL verify: rst_i pulsed during beat 5 -> all outputs at reset values, no bvalid, awready=1 one cycle after release.
